// File: rtl/mr_chips_pkg.sv
// rtl/mr_chips_pkg.sv - shared types and constants for the mr_chips memory arbiter
package mr_chips_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int MR_AW = 16;
    localparam int MR_DW = 16;

endpackage

// File: rtl/mr_mem_arbiter_if.sv
// rtl/mr_mem_arbiter_if.sv - fetch, data and memory bus bundle between core, arbiter and memory
interface mr_mem_arbiter_if
    import mr_chips_pkg::*;
#(
    parameter int AW = MR_AW,
    parameter int DW = MR_DW
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mr_sat_counter.sv
// rtl/mr_sat_counter.sv - saturating up-counter with synchronous clear
module mr_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mr_mem_arbiter.sv
// rtl/mr_mem_arbiter.sv - two-port issue/response arbiter for one synchronous memory
// Build option MR_ARB_RR_EN selects round-robin on conflict; otherwise data port has fixed priority.
module mr_mem_arbiter
    import mr_chips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    mr_mem_arbiter_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    arb_state_t state;
    logic       resp_port;
    logic       any_req;
    logic       both_req;
    logic       grant;
    logic       win_port;
    logic       pref_port;
    logic       resp_live;
    logic       conflict_en;
    logic [$bits(bus.if_rdata)-1:0] if_rdata_q;
    logic [$bits(bus.d_rdata)-1:0]  d_rdata_q;

`ifdef MR_ARB_RR_EN
    // Pointer names the port that wins the next conflict; it flips away from every winner.
    logic rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= PORT_D;
        end else if (grant) begin
            rr_ptr <= ~win_port;
        end
    end

    assign pref_port = rr_ptr;
`else
    assign pref_port = PORT_D;
`endif

    always_comb begin
        any_req  = bus.if_req | bus.d_req;
        both_req = bus.if_req & bus.d_req;
        grant    = (state == ARB_IDLE) && any_req && !reset;
        if (both_req) begin
            win_port = pref_port;
        end else begin
            win_port = bus.d_req ? PORT_D : PORT_IF;
        end
    end

    assign conflict_en = (state == ARB_IDLE) && both_req && !reset;
    // Gating with reset abandons a response that is in flight when reset arrives.
    assign resp_live   = (state == ARB_RESP) && !reset;

    assign bus.if_gnt    = grant && (win_port == PORT_IF);
    assign bus.d_gnt     = grant && (win_port == PORT_D);
    assign bus.mem_en    = grant;
    assign bus.mem_we    = bus.d_gnt && bus.d_we;
    assign bus.mem_addr  = !grant ? '0 : ((win_port == PORT_D) ? bus.d_addr : bus.if_addr);
    assign bus.mem_wdata = bus.d_gnt ? bus.d_wdata : '0;

    assign busy       = resp_live;
    assign bus.if_ack = resp_live && (resp_port == PORT_IF);
    assign bus.d_ack  = resp_live && (resp_port == PORT_D);
    assign bus.if_rdata = bus.if_ack ? bus.mem_rdata : if_rdata_q;
    assign bus.d_rdata  = bus.d_ack  ? bus.mem_rdata : d_rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            resp_port  <= PORT_D;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        state     <= ARB_RESP;
                        resp_port <= win_port;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
            if (bus.if_ack) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (bus.d_ack) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    mr_sat_counter #(
        .W(CNT_W)
    ) u_conflict_cnt (
        .clk  (clk),
        .clear(reset),
        .en   (conflict_en),
        .count(conflict_cnt)
    );

endmodule

// File: tb/tb_mr_mem_arbiter.sv
// tb/tb_mr_mem_arbiter.sv - directed self-checking bench for mr_mem_arbiter
module tb_mr_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] conflict_cnt;
    logic        busy_s;
    logic [1:0]  conflict_cnt_s;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] mem [0:1023];

    mr_mem_arbiter_if bus ();
    mr_mem_arbiter_if bus_s ();

    always #5 clk = ~clk;

    mr_mem_arbiter #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .busy        (busy),
        .conflict_cnt(conflict_cnt)
    );

    mr_mem_arbiter #(.CNT_W(2)) dut_s (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_s.slave),
        .busy        (busy_s),
        .conflict_cnt(conflict_cnt_s)
    );

    assign bus_s.if_req    = bus.if_req;
    assign bus_s.if_addr   = bus.if_addr;
    assign bus_s.d_req     = bus.d_req;
    assign bus_s.d_we      = bus.d_we;
    assign bus_s.d_addr    = bus.d_addr;
    assign bus_s.d_wdata   = bus.d_wdata;
    assign bus_s.mem_rdata = bus.mem_rdata;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem[bus.mem_addr[9:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        logic exp_d;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[4] = 16'h1234;
        bus.mem_rdata = 16'h0000;
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0004;
        bus.d_req = 1'b1;  bus.d_we = 1'b0; bus.d_addr = 16'h0010; bus.d_wdata = 16'h0000;

        for (int i = 0; i < 5; i++) begin
            next_cycle(); #1;
            check("reset_outs", {29'd0, bus.if_gnt | bus.d_gnt | bus.mem_en, bus.if_ack | bus.d_ack | busy,
                                 |(bus.if_rdata | bus.d_rdata)}, 32'd0);
            check("reset_cnt", {16'd0, conflict_cnt}, 32'd0);
        end

        next_cycle(); reset = 1'b0; #1;
        check("first_gnt", {30'd0, bus.d_gnt, bus.if_gnt}, 32'd2);
        next_cycle(); bus.if_req = 1'b0; bus.d_req = 1'b0; #1;
        check("first_ack", {29'd0, bus.d_ack, bus.if_ack, busy}, 32'd5);

        next_cycle(); bus.if_req = 1'b1; bus.if_addr = 16'h0004; #1;
        check("if_gnt", {30'd0, bus.if_gnt, bus.mem_en}, 32'd3);
        check("if_mem_addr", {15'd0, bus.mem_we, bus.mem_addr}, 32'h0000_0004);
        next_cycle(); bus.if_req = 1'b0; #1;
        check("if_ack_busy", {29'd0, bus.if_ack, busy, bus.if_gnt}, 32'd6);
        check("if_rdata", {16'd0, bus.if_rdata}, 32'h1234);

        next_cycle(); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'hBEEF; #1;
        check("wr_gnt", {29'd0, bus.d_gnt, bus.mem_we, bus.mem_en}, 32'd7);
        check("wr_wdata", {16'd0, bus.mem_wdata}, 32'hBEEF);
        next_cycle(); bus.d_req = 1'b0; bus.d_we = 1'b0; #1;
        check("wr_ack", {30'd0, bus.d_ack, bus.mem_we}, 32'd2);
        check("if_rdata_hold", {16'd0, bus.if_rdata}, 32'h1234);
        next_cycle(); bus.d_req = 1'b1; #1;
        check("rd_gnt", {30'd0, bus.d_gnt, bus.mem_we}, 32'd2);
        next_cycle(); bus.d_req = 1'b0; #1;
        check("rd_ack", {31'd0, bus.d_ack}, 32'd1);
        check("rd_data", {16'd0, bus.d_rdata}, 32'hBEEF);
        next_cycle(); #1;
        check("rd_hold", {15'd0, bus.d_ack, bus.d_rdata}, 32'h0000_BEEF);

        next_cycle(); reset = 1'b1; #1;
        next_cycle(); reset = 1'b0; bus.if_req = 1'b1; bus.d_req = 1'b1; bus.d_addr = 16'h0010; #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin next_cycle(); #1; end
`ifdef MR_ARB_RR_EN
            exp_d = ((c / 2) % 2) == 0;
`else
            exp_d = 1'b1;
`endif
            if ((c % 2) == 0)
                check($sformatf("conf_gnt_%0d", c), {30'd0, bus.d_gnt, bus.if_gnt}, exp_d ? 32'd2 : 32'd1);
            else
                check($sformatf("conf_ack_%0d", c), {30'd0, bus.d_ack, bus.if_ack}, exp_d ? 32'd2 : 32'd1);
            if (c == 8) check("conf_cnt_4", {16'd0, conflict_cnt}, 32'd4);
        end

        next_cycle(); #1;
        check("conf_cnt_5", {16'd0, conflict_cnt}, 32'd5);
        check("conf_cnt_sat", {30'd0, conflict_cnt_s}, 32'd3);
        next_cycle(); reset = 1'b1; #1;
        check("rst_resp_noack", {29'd0, bus.if_ack, bus.d_ack, busy}, 32'd0);
        next_cycle(); reset = 1'b0; bus.d_req = 1'b0; bus.if_req = 1'b1; #1;
        check("rst_resp_idle", {29'd0, bus.if_gnt, bus.if_ack | bus.d_ack, busy}, 32'd4);
        next_cycle(); bus.if_req = 1'b0; #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
